// File: rtl/disp_pkg.sv
// Shared constants for the seven-segment display path: digit count,
// active-low hex font and the all-off patterns for anodes and segments.
package disp_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Active-low gfedcba patterns, indexed by nibble value 0..F.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex7seg.sv
// Combinational nibble to active-low seven-segment pattern lookup.
module hex7seg
  import disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed hex display driver: per-frame snapshot of the
// input word, anti-ghost blank gap per digit slot and leading-zero blanking.
module seg7_scan_driver
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_reg,
  input  logic        lz_en,
  input  logic [7:0]  dp_mask,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int PW = $clog2(REFRESH_DIV);

  logic [PW-1:0] pcnt;
  logic [2:0]    didx;
  logic [31:0]   snap_data;
  logic          snap_lz;
  logic [7:0]    snap_dp;
  logic          load_pend;

  logic          slot_end;
  logic          snap_load;
  logic [3:0]    cur_nib;
  logic [6:0]    cur_seg;
  logic [7:0]    lz_blank;
  logic          zero_run;

  assign slot_end  = (pcnt == PW'(REFRESH_DIV - 1));
  // Snapshot at the frame boundary, or once right after reset so the
  // first frame already shows live data.
  assign snap_load = load_pend | (slot_end & (didx == 3'd7));
  assign cur_nib   = snap_data[{didx, 2'b00} +: 4];

  hex7seg u_hex7seg (
    .nibble (cur_nib),
    .seg    (cur_seg)
  );

  // Digit k blanks when every nibble from the top down to k is zero;
  // digit 0 is excluded so an all-zero word still reads "0".
  always_comb begin
    lz_blank = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run    = zero_run & (snap_data[4*k +: 4] == 4'h0);
      lz_blank[k] = snap_lz & zero_run;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt       <= '0;
      didx       <= '0;
      snap_data  <= '0;
      snap_lz    <= 1'b0;
      snap_dp    <= '0;
      load_pend  <= 1'b1;
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      pcnt <= slot_end ? '0 : pcnt + 1'b1;
      if (slot_end) begin
        didx <= didx + 3'd1;
      end
      if (snap_load) begin
        snap_data <= data_reg;
        snap_lz   <= lz_en;
        snap_dp   <= dp_mask;
        load_pend <= 1'b0;
      end
      frame_tick <= snap_load;
      // seg/dp switch to the new digit in the same cycle the anodes go dark,
      // so the pattern is stable for the whole lit part of the slot.
      an  <= (pcnt < PW'(BLANK_CYC)) ? AN_OFF : ~(8'd1 << didx);
      seg <= lz_blank[didx] ? SEG_OFF : cur_seg;
      dp  <= ~snap_dp[didx];
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Frame-by-frame check of the scan driver against a table of display words
// and their expected per-digit patterns, plus reset corner cases.
module tb_seg7_scan_driver;

  localparam int RD = 8;
  localparam int BC = 2;
  localparam int NV = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_reg;
  logic        lz_en;
  logic [7:0]  dp_mask;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .REFRESH_DIV (RD),
    .BLANK_CYC   (BC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_reg   (data_reg),
    .lz_en      (lz_en),
    .dp_mask    (dp_mask),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  typedef struct {
    logic [31:0] data;
    logic        lz;
    logic [7:0]  dpm;
    logic [55:0] seg_exp;  // {digit7 .. digit0}, 7 bits each
    logic [7:0]  dp_exp;   // active-low, bit k = digit k
  } vec_t;

  vec_t        vecs [NV];
  logic [63:0] exp_q[$];
  int          checks   = 0;
  int          failures = 0;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic drive_vec(input int i);
    data_reg = vecs[i].data;
    lz_en    = vecs[i].lz;
    dp_mask  = vecs[i].dpm;
    exp_q.push_back({vecs[i].seg_exp, vecs[i].dp_exp});
  endtask

  // Checks one full frame cycle by cycle. On entry the bench sits on the
  // cycle whose frame_tick announced this frame. Mid-frame (digit 3) the
  // next vector is driven; it must not show before the following frame.
  task automatic check_frame(input int idx, input bit from_reset);
    logic [63:0] e;
    logic [55:0] se;
    logic [7:0]  de;
    logic [7:0]  exp_an;
    logic        exp_ft;
    int          pc;
    int          d;
    if (exp_q.size() == 0) begin
      check($sformatf("queue_empty_f%0d", idx), 32'd1, 32'd0);
      return;
    end
    e  = exp_q.pop_front();
    se = e[63:8];
    de = e[7:0];
    for (int k = 0; k < 8 * RD; k++) begin
      if (k > 0 || !from_reset) step();
      pc     = k % RD;
      d      = k / RD;
      exp_an = (pc < BC) ? 8'hFF : ~(8'd1 << d);
      exp_ft = (k == 8 * RD - 1) || (from_reset && k == 0);
      check($sformatf("an_f%0d_k%0d", idx, k), an, exp_an);
      check($sformatf("tick_f%0d_k%0d", idx, k), frame_tick, exp_ft);
      if (!(from_reset && k == 0)) begin
        check($sformatf("seg_f%0d_k%0d", idx, k), seg, se[d*7 +: 7]);
        check($sformatf("dp_f%0d_k%0d", idx, k), dp, de[d]);
      end
      if (k == 3 * RD + 3 && idx + 1 < NV) drive_vec(idx + 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h89AB_CDEF, 1'b0, 8'h00,
                {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}, 8'hFF};
    vecs[1] = '{32'h0000_00A0, 1'b1, 8'h00,
                {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40}, 8'hFF};
    vecs[2] = '{32'h0000_0000, 1'b1, 8'h05,
                {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, 8'hFA};
    vecs[3] = '{32'h1111_1111, 1'b0, 8'h00,
                {7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79}, 8'hFF};
    vecs[4] = '{32'h2222_2222, 1'b0, 8'h00,
                {7'h24, 7'h24, 7'h24, 7'h24, 7'h24, 7'h24, 7'h24, 7'h24}, 8'hFF};
    vecs[5] = '{32'h0000_0000, 1'b0, 8'hFF,
                {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 8'h00};
    vecs[6] = '{32'h0F00_A000, 1'b1, 8'h80,
                {7'h7F, 7'h0E, 7'h40, 7'h40, 7'h08, 7'h40, 7'h40, 7'h40}, 8'h7F};
    vecs[7] = '{32'h1234_5670, 1'b1, 8'h00,
                {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h40}, 8'hFF};

    rst = 1'b1;
    drive_vec(0);
    repeat (3) step();
    check("rst_an", an, 8'hFF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1'b1);
    check("rst_tick", frame_tick, 1'b0);

    rst = 1'b0;
    step();
    check_frame(0, 1'b1);
    for (int i = 1; i < NV; i++) check_frame(i, 1'b0);

    // Run into digit 5 of the next frame, then pulse reset mid-slot.
    repeat (5 * RD + 5) step();
    check("pre_rst_an", an, 8'hDF);
    rst = 1'b1;
    step();
    check("midrst_an", an, 8'hFF);
    check("midrst_seg", seg, 7'h7F);
    check("midrst_dp", dp, 1'b1);
    check("midrst_tick", frame_tick, 1'b0);
    rst = 1'b0;
    exp_q.push_back({vecs[NV-1].seg_exp, vecs[NV-1].dp_exp});
    step();
    check_frame(NV - 1, 1'b1);
    check("queue_left", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
